// File: rtl/data_sram_bridge.sv
// Bridge from the memory-access stage's one-cycle data request to the SRAM-like
// req/addr_ok/data_ok bus: stalls the pipeline per access and holds the read word.
module data_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    input  logic              wb_stall_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stallreq_o,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              data_data_ok_i
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_e;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    req_t              req_q, req_d, req_new;
    logic [ADDR_W-1:0] pa;
    logic              drain;

    // Request decode from the stage's current inputs; captured only on issue.
    always_comb begin
        req_new       = '0;
        req_new.wr    = |mem_sel_i;
        case (mem_sel_i)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: req_new.size = 2'd0;
            4'b1100, 4'b0011:                   req_new.size = 2'd1;
            default:                            req_new.size = 2'd2;
        endcase
        pa = mem_addr_i[ADDR_W-1] ? {3'b000, mem_addr_i[ADDR_W-4:0]} : mem_addr_i;
        req_new.addr  = req_new.wr ? pa : {pa[ADDR_W-1:2], 2'b00};
        req_new.wdata = mem_wdata_i;
    end

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        case (state_q)
            IDLE: begin
                if (mem_ce_i && !flush_i) begin
                    req_d   = req_new;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // Request must stay up until accepted, even when flushed.
                if (flush_i)        cancel_d = 1'b1;
                if (data_addr_ok_i) state_d  = DATA;
            end
            DATA: begin
                if (flush_i) cancel_d = 1'b1;
                if (data_data_ok_i) begin
                    if (cancel_q || flush_i) begin
                        state_d  = IDLE;
                        cancel_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                        if (!req_q.wr) rdata_d = data_rdata_i;
                    end
                end
            end
            HOLD: begin
                if (flush_i || !wb_stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            rdata_q  <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
        end
    end

    // A cancelled drain still blocks a new access until its data_ok returns.
    always_comb begin
        drain      = (state_q == ADDR || state_q == DATA) && cancel_q;
        stallreq_o = (state_q == IDLE && mem_ce_i && !flush_i) ||
                     (state_q == ADDR) ||
                     (state_q == DATA && !cancel_q) ||
                     (drain && mem_ce_i);
    end

    assign data_req_o   = (state_q == ADDR);
    assign data_wr_o    = req_q.wr;
    assign data_size_o  = req_q.size;
    assign data_addr_o  = req_q.addr;
    assign data_wdata_o = req_q.wdata;
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: directed scenarios plus randomized accesses checked
// against a transaction-level model of mapping, size, stall and read-data rules.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, flush, wbst, aok, dok;
    logic [3:0]  sel_i;
    logic [31:0] addr_i, wdata_i, rdata_i;
    logic [31:0] rdata, d_addr, d_wdata;
    logic        stallreq, req, d_wr;
    logic [1:0]  d_size;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(ce), .mem_sel_i(sel_i), .mem_addr_i(addr_i), .mem_wdata_i(wdata_i),
        .flush_i(flush), .wb_stall_i(wbst),
        .rdata_o(rdata), .stallreq_o(stallreq),
        .data_req_o(req), .data_wr_o(d_wr), .data_size_o(d_size),
        .data_addr_o(d_addr), .data_wdata_o(d_wdata),
        .data_addr_ok_i(aok), .data_rdata_i(rdata_i), .data_data_ok_i(dok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_size(input logic [3:0] sel);
        if ($countones(sel) == 1) return 2'd0;
        if (sel == 4'b1100 || sel == 4'b0011) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] m_addr(input logic [3:0] sel, input logic [31:0] a);
        logic [31:0] pa;
        pa = a[31] ? (a & 32'h1FFF_FFFF) : a;
        return (sel == 4'b0000) ? (pa & 32'hFFFF_FFFC) : pa;
    endfunction

    // fl: index over the ADDR+DATA cycles at which flush pulses (-1 = none).
    // pend: a new access is waiting during a cancelled drain.
    // hflush: leave HOLD by flush instead of by wb_stall dropping.
    task automatic access(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int adly, input int ddly, input int hold,
                          input int fl, input bit pend, input bit hflush);
        int          k;
        bit          canc;
        logic [1:0]  esz;
        logic [31:0] ea;
        esz  = m_size(sel);
        ea   = m_addr(sel, addr);
        canc = 1'b0;
        k    = 0;
        @(negedge clk);
        ce = 1'b1; sel_i = sel; addr_i = addr; wdata_i = wdata;
        flush = 1'b0; aok = 1'b0; dok = 1'b0; wbst = 1'b0;
        #1;
        chk("idle_stall", stallreq, 1);
        chk("idle_req", req, 0);
        chk("idle_rdata", rdata, exp_rdata);
        for (int i = 0; i <= adly; i++) begin
            @(negedge clk);
            ce = canc ? pend : 1'b1;
            aok = (i == adly);
            flush = (k == fl);
            if (!canc) begin
                sel_i = 4'($urandom_range(15)); addr_i = $urandom; wdata_i = $urandom;
            end
            #1;
            chk("addr_req", req, 1);
            chk("addr_stall", stallreq, 1);
            chk("bus_addr", d_addr, ea);
            chk("bus_size", d_size, esz);
            chk("bus_wr", d_wr, sel != 4'b0000);
            chk("bus_wdata", d_wdata, wdata);
            if (flush) canc = 1'b1;
            k++;
        end
        for (int j = 0; j <= ddly; j++) begin
            @(negedge clk);
            ce = canc ? pend : 1'b1;
            aok = 1'b0;
            dok = (j == ddly);
            flush = (k == fl);
            rdata_i = (j == ddly) ? rd : $urandom;
            #1;
            chk("data_req", req, 0);
            chk("data_stall", stallreq, canc ? pend : 1'b1);
            if (flush) canc = 1'b1;
            k++;
        end
        if (!canc && sel == 4'b0000) exp_rdata = rd;
        if (canc) begin
            if (!pend) begin
                @(negedge clk);
                ce = 1'b0; flush = 1'b0; dok = 1'b0;
                #1;
                chk("drained_stall", stallreq, 0);
                chk("drained_req", req, 0);
                chk("drained_rdata", rdata, exp_rdata);
            end
        end else begin
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                ce = 1'b1; aok = 1'b0; dok = 1'b0;
                flush = hflush && (h == hold);
                wbst  = (h < hold) || hflush;
                #1;
                chk("hold_stall", stallreq, 0);
                chk("hold_req", req, 0);
                chk("hold_rdata", rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ce = 1'b0; sel_i = '0; addr_i = '0; wdata_i = '0; rdata_i = '0;
        flush = 1'b0; wbst = 1'b0; aok = 1'b0; dok = 1'b0;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", rdata, 0);
        chk("rst_req", req, 0);
        chk("rst_wr", d_wr, 0);
        chk("rst_size", d_size, 0);
        chk("rst_addr", d_addr, 0);
        chk("rst_wdata", d_wdata, 0);
        @(negedge clk);
        rst = 1'b1;

        access(4'b0000, 32'h8000_1006, 32'h0, 32'hDEADBEEF, 0, 0, 0, -1, 1'b0, 1'b0);
        access(4'b0010, 32'hA000_0013, 32'h5A5A_5A5A, 32'h0, 3, 1, 0, -1, 1'b0, 1'b0);
        access(4'b1100, 32'h0040_0000, 32'h1234_ABCD, 32'h0, 0, 0, 0, -1, 1'b0, 1'b0);
        access(4'b0000, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1, 0, 5, -1, 1'b0, 1'b0);
        access(4'b0000, 32'h0000_3000, 32'h0, 32'h1234_5678, 0, 2, 0, 1, 1'b1, 1'b0);
        access(4'b1111, 32'hBFC0_0100, 32'h7777_0000, 32'h0, 0, 0, 0, -1, 1'b0, 1'b0);

        // Reset while a request is outstanding in ADDR
        @(negedge clk);
        ce = 1'b1; sel_i = 4'b0000; addr_i = 32'h1234_5678; aok = 1'b0; dok = 1'b0; flush = 1'b0;
        #1 chk("pre_rst_stall", stallreq, 1);
        @(negedge clk);
        #1 chk("pre_rst_req", req, 1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_edge_req", req, 1);
        @(negedge clk);
        rst = 1'b1; ce = 1'b0;
        #1;
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_wr", d_wr, 0);
        chk("mid_rst_size", d_size, 0);
        chk("mid_rst_addr", d_addr, 0);
        chk("mid_rst_wdata", d_wdata, 0);
        chk("mid_rst_stall", stallreq, 0);
        exp_rdata = '0;
        access(4'b0000, 32'h1234_5678, 32'h0, 32'h0BAD_CAFE, 0, 0, 1, -1, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] s;
            int         ad, dd, fl;
            s  = ($urandom_range(2) == 0) ? 4'b0000 : 4'($urandom_range(15));
            ad = $urandom_range(3);
            dd = $urandom_range(3);
            fl = ($urandom_range(3) == 0) ? int'($urandom_range(ad + dd + 1)) : -1;
            access(s, $urandom, $urandom, $urandom, ad, dd, $urandom_range(3), fl,
                   1'($urandom_range(1)), 1'($urandom_range(3) == 0));
        end

        @(negedge clk);
        ce = 1'b0; flush = 1'b0; wbst = 1'b0;
        #1 chk("final_rdata", rdata, exp_rdata);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the memory-access stage.
- Converts that stage's single-cycle data-memory request into a transaction on the SoC's SRAM-like data bus (req/addr_ok/data_ok).
- Stalls the pipeline until the transaction completes, then holds the raw read word for the stage's load extraction logic.
- Applies kseg0/kseg1 address mapping and handles exception flushes that arrive while a transaction is in flight.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- mem_ce_i  in  1  data-memory access requested by memory-access stage
- mem_sel_i  in  4  byte select; 4'b0000 = load (word read), nonzero = store lanes
- mem_addr_i  in  32  access address (virtual)
- mem_wdata_i  in  32  store data, already lane-replicated
- flush_i  in  1  pipeline flush (exception/eret); current access is cancelled
- wb_stall_i  in  1  downstream pipeline stalled; memory-access stage holds its instruction
- rdata_o  out  32  raw 32-bit read word returned to memory-access stage
- stallreq_o  out  1  stall request to pipeline control
- data_req_o  out  1  bus request
- data_wr_o  out  1  1 = write
- data_size_o  out  2  0 = byte, 1 = half, 2 = word
- data_addr_o  out  32  physical bus address
- data_wdata_o  out  32  bus write data
- data_addr_ok_i  in  1  bus accepted address
- data_rdata_i  in  32  bus read data
- data_data_ok_i  in  1  bus data phase complete

Behaviour:
- Reset: when rst==0 at a clk edge:
  - state=IDLE, cancel=0;
  - all outputs 0: rdata_o, data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o.
  - Reset mid-transaction abandons the transaction; no bus cleanup.
- States: IDLE, ADDR, DATA, HOLD.
- Write detect: wr = (mem_sel_i != 0).
- Size decode:
  - 1000/0100/0010/0001 -> 0; 1100/0011 -> 1; 1111 or 0000 -> 2.
  - Any other pattern is treated as size 2, write.
- Address mapping: pa = addr[31] ? {3'b000, addr[28:0]} : addr.
  - Loads: data_addr_o = {pa[31:2], 2'b00}.
  - Stores: data_addr_o = pa unchanged.
- IDLE:
  - If mem_ce_i && !flush_i: latch data_wr_o, data_size_o, data_addr_o and data_wdata_o, then go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - data_req_o=1; request fields stay stable.
  - On data_addr_ok_i: go to DATA; data_req_o is 0 from the next cycle.
  - The request is never withdrawn before addr_ok, even if flushed.
- DATA:
  - Wait for data_data_ok_i. The bus never asserts data_ok in the same cycle as its addr_ok.
  - On data_ok with a read and cancel==0: rdata_o <= data_rdata_i.
  - On data_ok: go to HOLD if cancel==0; otherwise go to IDLE and clear cancel.
- HOLD:
  - The access is complete and the result is valid.
  - If flush_i || !wb_stall_i: go to IDLE. Otherwise stay, because the same instruction is still present and must not be reissued.
- cancel: set when flush_i==1 in ADDR or DATA. Read data is then discarded and HOLD is skipped.
- stallreq_o, combinational:
  - 1 when (IDLE && mem_ce_i && !flush_i), or ADDR, or (DATA && !cancel).
  - 1 when a cancelled drain is in progress and mem_ce_i==1; a new access waits until the drain finishes.
  - 0 otherwise, including throughout HOLD.
- Latency: with addr_ok on the first request cycle and data_ok on the next, stallreq_o is high for 3 cycles. rdata_o is valid from the 4th cycle (HOLD).
- rdata_o is held across stores and in IDLE; it changes only on a non-cancelled read data_ok.
- Simultaneous flush_i and data_ok in DATA: data is discarded and the next state is IDLE.

Test Plan:
- Word load: sel=0000, addr=0x8000_1006, addr_ok on 1st req cycle, data_ok 1 cycle later with 0xDEADBEEF.
  -> bus addr=0x0000_1004, size=2, wr=0; stallreq high 3 cycles; rdata_o=0xDEADBEEF in HOLD.
- Byte store: sel=0010, addr=0xA000_0013, wdata=0x5A5A5A5A, addr_ok delayed 3 cycles.
  -> req held 4 cycles with stable fields; addr=0x0000_0013, size=0, wr=1; rdata_o unchanged.
- Half store: sel=1100, addr=0x0040_0000 -> size=1, addr unmapped 0x0040_0000.
- HOLD with wb_stall_i=1 for 5 cycles -> no new data_req_o, stallreq_o=0, rdata_o stable; IDLE the cycle after wb_stall_i drops.
- flush_i pulsed in DATA of a load returning 0x12345678.
  -> rdata_o keeps its old value; HOLD skipped; a new mem_ce_i is stalled until data_ok, then issued.
- rst=0 asserted in ADDR -> next cycle all outputs 0 and state IDLE; a pending ce starts a fresh request after rst=1.
